// File: rtl/word_reader_pkg.sv
// -----------------------------------------------------------------------------
// word_reader_pkg
// Shared types for the word reader: the word-assembly state encoding, the
// identifiers of the recognised words, and a helper that maps a finished
// word state to its word identifier.
// -----------------------------------------------------------------------------
package word_reader_pkg;

    // Word-assembly state. EMPTY must stay at zero so that a cleared
    // register means "no letters collected yet".
    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        S_I   = 3'd1,
        S_T   = 3'd2,
        S_IT  = 3'd3,
        S_IN  = 3'd4,
        S_TI  = 3'd5,
        S_TIN = 3'd6,
        BAD   = 3'd7
    } state_t;

    // Identifiers of the recognised words.
    localparam logic [1:0] WORD_NONE = 2'd0;
    localparam logic [1:0] WORD_IT   = 2'd1;
    localparam logic [1:0] WORD_IN   = 2'd2;
    localparam logic [1:0] WORD_TIN  = 2'd3;

    // Word identifier of a state at the moment a space closes the word.
    function automatic logic [1:0] word_of(input state_t s);
        case (s)
            S_IT:    word_of = WORD_IT;
            S_IN:    word_of = WORD_IN;
            S_TIN:   word_of = WORD_TIN;
            default: word_of = WORD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one on each cycle with inc high and holds at
// all-ones instead of wrapping.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears the count
//   inc    increment request for this cycle
//   count  current count (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/word_reader.sv
// -----------------------------------------------------------------------------
// word_reader
// Assembles one-cycle letter strobes (I, T, N) into words separated by a
// space strobe, recognises "IT", "IN" and "TIN", pulses one output per
// recognised word and keeps a saturating count of recognised words.
//
// Strobe semantics: every input strobe is a single-cycle event sampled on
// the rising edge of clk; there is no back-pressure. A space edge first
// appends any same-edge letters, then evaluates the word and restarts from
// EMPTY, so a new word may begin on the very next edge.
//
// Ports:
//   clk         rising-edge clock
//   restart_n   asynchronous active-low reset
//   letter_i    strobe: letter I completed
//   letter_t    strobe: letter T completed
//   letter_n    strobe: letter N completed
//   space       strobe: word boundary
//   word_it     one-cycle pulse, "IT" recognised (cycle after the space edge)
//   word_in     one-cycle pulse, "IN" recognised
//   word_tin    one-cycle pulse, "TIN" recognised
//   word_count  saturating count of recognised words (COUNT_W bits)
//   err         [WORD_READER_ERR_EN only] pulse, non-empty unrecognised word
//   err_count   [WORD_READER_ERR_EN only] saturating count of err pulses
//
// Configuration macro: WORD_READER_ERR_EN adds err and err_count.
// -----------------------------------------------------------------------------
module word_reader
    import word_reader_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               restart_n,
    input  logic               letter_i,
    input  logic               letter_t,
    input  logic               letter_n,
    input  logic               space,
    output logic               word_it,
    output logic               word_in,
    output logic               word_tin,
    output logic [COUNT_W-1:0] word_count
`ifdef WORD_READER_ERR_EN
    ,
    output logic               err,
    output logic [COUNT_W-1:0] err_count
`endif
);

    state_t     state;
    state_t     state_next;
    state_t     after_letters;   // state once this edge's letters are appended
    logic       multi_letter;
    logic [1:0] word_id_next;
    logic       err_next;

    assign multi_letter = (letter_i & letter_t) | (letter_i & letter_n) |
                          (letter_t & letter_n);

    // State register.
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the word decision for this edge.
    always_comb begin
        after_letters = state;
        state_next    = state;
        word_id_next  = WORD_NONE;
        err_next      = 1'b0;

        if (multi_letter) begin
            after_letters = BAD;
        end else if (letter_i | letter_t | letter_n) begin
            case (state)
                EMPTY:   after_letters = letter_i ? S_I :
                                         (letter_t ? S_T : BAD);
                S_I:     after_letters = letter_t ? S_IT :
                                         (letter_n ? S_IN : BAD);
                S_T:     after_letters = letter_i ? S_TI : BAD;
                S_TI:    after_letters = letter_n ? S_TIN : BAD;
                default: after_letters = BAD;
            endcase
        end

        if (space) begin
            word_id_next = word_of(after_letters);
            err_next     = (after_letters != EMPTY) && (word_of(after_letters) == WORD_NONE);
            state_next   = EMPTY;
        end else begin
            state_next   = after_letters;
        end
    end

    // Word pulses are registered so they appear in the cycle after the space.
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            word_it  <= 1'b0;
            word_in  <= 1'b0;
            word_tin <= 1'b0;
        end else begin
            word_it  <= (word_id_next == WORD_IT);
            word_in  <= (word_id_next == WORD_IN);
            word_tin <= (word_id_next == WORD_TIN);
        end
    end

    // Counter updates on the same edge as the pulse register.
    sat_counter #(.W(COUNT_W)) u_word_count (
        .clk   (clk),
        .rst_n (restart_n),
        .inc   (word_id_next != WORD_NONE),
        .count (word_count)
    );

`ifdef WORD_READER_ERR_EN
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            err <= 1'b0;
        end else begin
            err <= err_next;
        end
    end

    sat_counter #(.W(COUNT_W)) u_err_count (
        .clk   (clk),
        .rst_n (restart_n),
        .inc   (err_next),
        .count (err_count)
    );
`else
    // Without the error outputs the decision is simply not used.
    logic err_unused;
    assign err_unused = err_next;
`endif

endmodule

// File: doc/word_reader.md
Name: word_reader

Overview:
- Downstream consumer of the per-letter readers (i_reader and its sibling T and N readers).
- Takes their one-cycle letter strobes plus a word-boundary strobe, and assembles letters into words.
- Recognises the words "IT", "IN" and "TIN", pulses one output per recognised word, and keeps a saturating count of recognised words.
- Feeds the display/scoring logic of the word-reader exercise.

Parameters:
COUNT_W, 8, width of word_count; counter saturates at 2^COUNT_W-1.

Ports:
clk  input  1  rising-edge clock shared with the letter readers
restart_n  input  1  asynchronous active-low reset
letter_i  input  1  one-cycle strobe: letter I completed (from i_reader)
letter_t  input  1  one-cycle strobe: letter T completed
letter_n  input  1  one-cycle strobe: letter N completed
space  input  1  one-cycle strobe: word boundary
word_it  output  1  one-cycle pulse: "IT" recognised
word_in  output  1  one-cycle pulse: "IN" recognised
word_tin  output  1  one-cycle pulse: "TIN" recognised
word_count  output  COUNT_W  number of recognised words, saturating

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (restart_n). While restart_n=0: state=EMPTY, all word_* =0, word_count=0. Deassertion takes effect at the next rising edge.
- States: EMPTY, S_I, S_T, S_IT, S_IN, S_TI, S_TIN, BAD.
- Letter transitions, applied on an edge with exactly one letter strobe high and space=0:
  - EMPTY: I->S_I, T->S_T, N->BAD
  - S_I: T->S_IT, N->S_IN, I->BAD
  - S_T: I->S_TI, else BAD
  - S_TI: N->S_TIN, else BAD
  - S_IT, S_IN, S_TIN, BAD: any letter->BAD
- More than one letter strobe high in one cycle: the state goes to BAD.
- Space evaluation:
  - On an edge with space=1, the current word is evaluated after any same-cycle letter strobes are appended per the rules above. State then returns to EMPTY.
  - Evaluated state S_IT -> word_it=1 for exactly the next cycle. S_IN -> word_in. S_TIN -> word_tin.
  - Any other evaluated state (including EMPTY, S_I, S_TI, BAD) produces no pulse.
- Latency: the word pulse is registered and asserted in the cycle after the space edge. word_count increments on that same edge, so the new count is visible together with the pulse.
- Exclusivity: at most one word_* output is high in any cycle.
- Counter: increments by 1 per recognised word. At 2^COUNT_W-1 it holds, with no wrap.
- Back-to-back words: a space followed immediately by letters on the next edge is legal. The new word starts from EMPTY with no lost cycle.
- Reset mid-word: the partial word is discarded, the count is cleared, and no pulse is emitted.

Optional Feature:
- Macro: WORD_READER_ERR_EN.
- When defined:
  - An extra output port, err (1 bit), is added.
  - err pulses for one cycle, aligned like the word pulses, when a space evaluates a non-EMPTY state that is not a recognised word.
  - A second saturating counter, err_count (COUNT_W bits), is added as an output.
  - Both reset to 0.
- When undefined: neither port exists, and behaviour is otherwise identical.

Decomposition:
- Package word_reader_pkg holds:
  - the state enum (3-bit encoding, EMPTY=0)
  - localparams for the word IDs
- Natural sub-module: sat_counter. It is parameterised by width, has inputs inc and asynchronous active-low reset, and holds at all-ones. It is instantiated once for word_count and once more for err_count when WORD_READER_ERR_EN is defined.

Test Plan:
- Reset then strobes I, T, space on consecutive cycles -> word_it=1 for one cycle after the space edge; word_count 0->1.
- T, I, N, space -> word_tin pulse; word_count=1. Then I, N, space immediately afterwards -> word_in pulse; word_count=2; no dead cycle between words.
- I, I, space -> no word pulse; word_count unchanged. With WORD_READER_ERR_EN defined -> err pulse and err_count=1.
- letter_i and letter_t high in the same cycle, then space -> no pulse; with WORD_READER_ERR_EN defined, err pulses.
- COUNT_W=2: five recognised "IT" words -> word_count sequence 1, 2, 3, 3, 3; the word_it pulse still occurs each time.
- I, T, then restart_n low for 3 ns mid-cycle, then space -> no pulse; word_count=0 immediately on restart_n falling edge; next I, N, space -> word_in pulse with count=1.
